// File: rtl/ascon_pkg.sv
// Shared constants, FSM encoding and round-constant helper for the Ascon permutation.
// The S-box table documents the 5-bit substitution the bit-sliced logic implements.
package ascon_pkg;

    localparam int STATE_W = 320;
    localparam int WORD_W  = 64;
    localparam logic [3:0] MAX_ROUNDS = 4'd12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        DONE = ST_DONE
    } fsm_t;

    // Index is {x0,x1,x2,x3,x4} bit column, x0 as MSB.
    localparam logic [0:31][4:0] SBOX = {
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

endpackage

// File: rtl/ascon_round.sv
// One Ascon round: constant addition, bit-sliced S-box, linear diffusion layer.
// Purely combinational; round index selects the constant.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [3:0]  rnd,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [63:0] x2,
    input  logic [63:0] x3,
    input  logic [63:0] x4,
    output logic [63:0] y0,
    output logic [63:0] y1,
    output logic [63:0] y2,
    output logic [63:0] y3,
    output logic [63:0] y4
);

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    logic [63:0] a0, a2, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [63:0] c0, c1, c2, c3, c4;
    logic [63:0] b0, b1, b2, b3, b4;

    // Constant lands in the low byte of x2, ahead of the S-box input mixing.
    assign a0 = x0 ^ x4;
    assign a2 = x2 ^ {56'h0, round_const(rnd)} ^ x1;
    assign a4 = x4 ^ x3;

    assign t0 = ~a0 & x1;
    assign t1 = ~x1 & a2;
    assign t2 = ~a2 & x3;
    assign t3 = ~x3 & a4;
    assign t4 = ~a4 & a0;

    assign c0 = a0 ^ t1;
    assign c1 = x1 ^ t2;
    assign c2 = a2 ^ t3;
    assign c3 = x3 ^ t4;
    assign c4 = a4 ^ t0;

    assign b0 = c0 ^ c4;
    assign b1 = c1 ^ c0;
    assign b2 = ~c2;
    assign b3 = c3 ^ c2;
    assign b4 = c4;

    assign y0 = b0 ^ ror(b0, 19) ^ ror(b0, 28);
    assign y1 = b1 ^ ror(b1, 61) ^ ror(b1, 39);
    assign y2 = b2 ^ ror(b2, 1)  ^ ror(b2, 6);
    assign y3 = b3 ^ ror(b3, 10) ^ ror(b3, 17);
    assign y4 = b4 ^ ror(b4, 7)  ^ ror(b4, 41);

endmodule

// File: rtl/permutation_round_ctrl.sv
// Iterative Ascon p^a sequencer applying UNROLL rounds per clock; result after ceil(a/UNROLL) cycles.
// Single request in flight; result held until out_ready, new requests only accepted in IDLE.
module permutation_round_ctrl
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_rounds,
    input  logic [63:0] in_x0,
    input  logic [63:0] in_x1,
    input  logic [63:0] in_x2,
    input  logic [63:0] in_x3,
    input  logic [63:0] in_x4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_x0,
    output logic [63:0] out_x1,
    output logic [63:0] out_x2,
    output logic [63:0] out_x3,
    output logic [63:0] out_x4,
    output logic        busy
);

    fsm_t                 fsm;
    logic [3:0]           r;
    logic [STATE_W-1:0]   st_q;
    logic [STATE_W-1:0]   s1;
    logic [STATE_W-1:0]   nxt;
    logic [3:0]           step;
    logic [3:0]           r_nxt;
    logic [3:0]           a_c;

    assign a_c   = (in_rounds > MAX_ROUNDS) ? MAX_ROUNDS : in_rounds;
    assign step  = (UNROLL == 2 && r <= 4'd10) ? 4'd2 : 4'd1;
    assign r_nxt = r + step;

    assign in_ready = (fsm == IDLE) && !rst;

    assign out_x0 = st_q[319:256];
    assign out_x1 = st_q[255:192];
    assign out_x2 = st_q[191:128];
    assign out_x3 = st_q[127:64];
    assign out_x4 = st_q[63:0];

    ascon_round u_round0 (
        .rnd (r),
        .x0  (st_q[319:256]),
        .x1  (st_q[255:192]),
        .x2  (st_q[191:128]),
        .x3  (st_q[127:64]),
        .x4  (st_q[63:0]),
        .y0  (s1[319:256]),
        .y1  (s1[255:192]),
        .y2  (s1[191:128]),
        .y3  (s1[127:64]),
        .y4  (s1[63:0])
    );

    generate
        if (UNROLL == 2) begin : g_unroll2
            logic [STATE_W-1:0] s2;

            ascon_round u_round1 (
                .rnd (r + 4'd1),
                .x0  (s1[319:256]),
                .x1  (s1[255:192]),
                .x2  (s1[191:128]),
                .x3  (s1[127:64]),
                .x4  (s1[63:0]),
                .y0  (s2[319:256]),
                .y1  (s2[255:192]),
                .y2  (s2[191:128]),
                .y3  (s2[127:64]),
                .y4  (s2[63:0])
            );

            // Odd round counts finish with a single round; skip the second stage.
            assign nxt = (step == 4'd2) ? s2 : s1;
        end else begin : g_unroll1
            assign nxt = s1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= IDLE;
            r         <= 4'd0;
            st_q      <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        st_q <= {in_x0, in_x1, in_x2, in_x3, in_x4};
                        r    <= MAX_ROUNDS - a_c;
                        busy <= 1'b1;
                        if (a_c == 4'd0) begin
                            fsm       <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            fsm <= RUN;
                        end
                    end
                end
                RUN: begin
                    st_q <= nxt;
                    r    <= r_nxt;
                    if (r_nxt >= MAX_ROUNDS) begin
                        fsm       <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm       <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_permutation_round_ctrl.sv
// Drives UNROLL=1 and UNROLL=2 instances in lockstep and checks them against a table-driven Ascon model.
module tb_permutation_round_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_rounds = 4'd0;
    logic [63:0] in_x0 = '0, in_x1 = '0, in_x2 = '0, in_x3 = '0, in_x4 = '0;
    logic        out_ready = 1'b1;

    logic        ir1, ov1, busy1, ir2, ov2, busy2;
    logic [63:0] o1_x0, o1_x1, o1_x2, o1_x3, o1_x4;
    logic [63:0] o2_x0, o2_x1, o2_x2, o2_x3, o2_x4;
    logic [319:0] out1, out2;

    int n_checks = 0;
    int n_fail   = 0;

    assign out1 = {o1_x0, o1_x1, o1_x2, o1_x3, o1_x4};
    assign out2 = {o2_x0, o2_x1, o2_x2, o2_x3, o2_x4};

    always #5 clk = ~clk;

    permutation_round_ctrl #(.UNROLL(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_rounds(in_rounds),
        .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3), .in_x4(in_x4),
        .out_valid(ov1), .out_ready(out_ready),
        .out_x0(o1_x0), .out_x1(o1_x1), .out_x2(o1_x2), .out_x3(o1_x3), .out_x4(o1_x4),
        .busy(busy1)
    );

    permutation_round_ctrl #(.UNROLL(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_rounds(in_rounds),
        .in_x0(in_x0), .in_x1(in_x1), .in_x2(in_x2), .in_x3(in_x3), .in_x4(in_x4),
        .out_valid(ov2), .out_ready(out_ready),
        .out_x0(o2_x0), .out_x1(o2_x1), .out_x2(o2_x2), .out_x3(o2_x3), .out_x4(o2_x4),
        .busy(busy2)
    );

    // Reference model: S-box applied column by column from its truth table.
    logic [4:0] SB [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                            5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                            5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                            5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    int RA [5] = '{19, 61, 1, 10, 7};
    int RB [5] = '{28, 39, 6, 17, 41};

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        logic [127:0] d;
        d = {v, v};
        return d[n +: 64];
    endfunction

    function automatic logic [319:0] model_round(input logic [319:0] s, input int i);
        logic [63:0] w [5];
        logic [4:0]  idx, o;
        logic [7:0]  c;
        for (int k = 0; k < 5; k++) w[k] = s[319 - 64*k -: 64];
        c = 8'((15 - i) * 16 + i);
        w[2][7:0] = w[2][7:0] ^ c;
        for (int b = 0; b < 64; b++) begin
            idx = {w[0][b], w[1][b], w[2][b], w[3][b], w[4][b]};
            o = SB[idx];
            for (int k = 0; k < 5; k++) w[k][b] = o[4-k];
        end
        for (int k = 0; k < 5; k++) w[k] = w[k] ^ rotr(w[k], RA[k]) ^ rotr(w[k], RB[k]);
        return {w[0], w[1], w[2], w[3], w[4]};
    endfunction

    function automatic int clamp_a(input int a);
        return (a > 12) ? 12 : a;
    endfunction

    function automatic logic [319:0] model_perm(input logic [319:0] s, input int a);
        logic [319:0] t;
        t = s;
        for (int i = 12 - clamp_a(a); i < 12; i++) t = model_round(t, i);
        return t;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] v;
        for (int k = 0; k < 10; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    task automatic wait_ready();
        int g = 0;
        while (!(ir1 && ir2) && g < 50) begin
            @(posedge clk); #1;
            g++;
        end
    endtask

    task automatic accept(input logic [3:0] a, input logic [319:0] s);
        wait_ready();
        in_rounds = a;
        {in_x0, in_x1, in_x2, in_x3, in_x4} = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_rounds = 4'($urandom);
        {in_x0, in_x1, in_x2, in_x3, in_x4} = rand320();
    endtask

    // Issues one request and watches both instances; latency counts edges after acceptance.
    task automatic run_req(input logic [3:0] a, input logic [319:0] s,
                           output int lat1, output int lat2, output int bc1, output int bc2,
                           output logic [319:0] r1, output logic [319:0] r2);
        lat1 = -1; lat2 = -1; bc1 = 0; bc2 = 0; r1 = '0; r2 = '0;
        accept(a, s);
        for (int n = 0; n < 16; n++) begin
            if (busy1) bc1++;
            if (busy2) bc2++;
            if (ov1 && lat1 < 0) begin lat1 = n; r1 = out1; end
            if (ov2 && lat2 < 0) begin lat2 = n; r2 = out2; end
            @(posedge clk); #1;
        end
    endtask

    task automatic check_run(input string name, input int a, input logic [319:0] s);
        int l1, l2, b1, b2;
        logic [319:0] r1, r2, exp;
        int ac;
        ac  = clamp_a(a);
        exp = model_perm(s, a);
        run_req(4'(a), s, l1, l2, b1, b2, r1, r2);
        n_checks++;
        if (l1 !== ac) begin n_fail++; $display("FAIL %s lat_u1 got %0d want %0d", name, l1, ac); end
        n_checks++;
        if (l2 !== (ac + 1) / 2) begin n_fail++; $display("FAIL %s lat_u2 got %0d want %0d", name, l2, (ac + 1) / 2); end
        n_checks++;
        if (r1 !== exp) begin n_fail++; $display("FAIL %s data_u1 got %h want %h", name, r1, exp); end
        n_checks++;
        if (r2 !== exp) begin n_fail++; $display("FAIL %s data_u2 got %h want %h", name, r2, exp); end
        n_checks++;
        if (b1 !== ac + 1) begin n_fail++; $display("FAIL %s busy_u1 got %0d want %0d", name, b1, ac + 1); end
        n_checks++;
        if (b2 !== (ac + 1) / 2 + 1) begin n_fail++; $display("FAIL %s busy_u2 got %0d want %0d", name, b2, (ac + 1) / 2 + 1); end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ir1 !== 1'b0 || ir2 !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %b%b want 00", ir1, ir2); end
        n_checks++;
        if (ov1 !== 1'b0 || ov2 !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got ov=%b%b busy=%b%b want 0", ov1, ov2, busy1, busy2);
        end
        n_checks++;
        if (out1 !== 320'h0 || out2 !== 320'h0) begin n_fail++; $display("FAIL reset_state got %h / %h want 0", out1, out2); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (ir1 !== 1'b1 || ir2 !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got %b%b want 11", ir1, ir2); end
    endtask

    task automatic test_p12_iv();
        check_run("p12_iv", 12, {64'h80400c0600000000, 256'h0});
    endtask

    task automatic test_random_rounds();
        int alist [6] = '{6, 8, 1, 6, 8, 3};
        for (int i = 0; i < 6; i++) check_run($sformatf("rand_a%0d_%0d", alist[i], i), alist[i], rand320());
    endtask

    task automatic test_passthrough();
        check_run("pass_a0", 0, {5{64'h0123456789ABCDEF}});
    endtask

    task automatic test_clamp();
        logic [319:0] s;
        s = rand320();
        check_run("clamp_a15", 15, s);
        check_run("clamp_a13", 13, s);
    endtask

    task automatic test_backpressure();
        logic [319:0] s, snap1, snap2, exp;
        int g = 0;
        s = rand320();
        exp = model_perm(s, 6);
        out_ready = 1'b0;
        accept(4'd6, s);
        while (!(ov1 && ov2) && g < 30) begin @(posedge clk); #1; g++; end
        snap1 = out1; snap2 = out2;
        n_checks++;
        if (ov1 !== 1'b1 || ov2 !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout got %b%b want 11", ov1, ov2); end
        n_checks++;
        if (snap1 !== exp || snap2 !== exp) begin n_fail++; $display("FAIL bp_data got %h / %h want %h", snap1, snap2, exp); end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_rounds = 4'($urandom);
            {in_x0, in_x1, in_x2, in_x3, in_x4} = rand320();
            @(posedge clk); #1;
            n_checks++;
            if (out1 !== snap1 || out2 !== snap2 || ov1 !== 1'b1 || ov2 !== 1'b1 || ir1 !== 1'b0 || ir2 !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold cyc%0d ov=%b%b ir=%b%b stable=%b%b want ov=11 ir=00 stable=11",
                         c, ov1, ov2, ir1, ir2, out1 == snap1, out2 == snap2);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ov1 !== 1'b0 || ov2 !== 1'b0 || ir1 !== 1'b1 || ir2 !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got ov=%b%b ir=%b%b want ov=00 ir=11", ov1, ov2, ir1, ir2);
        end
        check_run("bp_next_a8", 8, rand320());
    endtask

    task automatic test_reset_abort();
        out_ready = 1'b1;
        accept(4'd12, rand320());
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (ov1 !== 1'b0 || ov2 !== 1'b0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
            n_fail++; $display("FAIL abort_flags got ov=%b%b busy=%b%b want 0", ov1, ov2, busy1, busy2);
        end
        n_checks++;
        if (out1 !== 320'h0 || out2 !== 320'h0) begin n_fail++; $display("FAIL abort_state got %h / %h want 0", out1, out2); end
        rst = 1'b0;
        #1;
        n_checks++;
        if (ir1 !== 1'b1 || ir2 !== 1'b1) begin n_fail++; $display("FAIL abort_idle got in_ready=%b%b want 11", ir1, ir2); end
        check_run("abort_fresh_p12", 12, rand320());
    endtask

    initial begin
        test_reset();
        test_p12_iv();
        test_random_rounds();
        test_passthrough();
        test_clamp();
        test_backpressure();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
